// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the parametrised single-bus datapath.
//   alu_op_e    : ALU operation codes carried on alu_op
//   SRC_*       : bus source offsets, added to NREGS to form a bus_src index
//   md_state_e  : state of the iterative multiply/divide sequencer
//   is_iter_op  : true for the operations that run on the iterative unit
package bus_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_NEG  = 4'd9,
        OP_NOT  = 4'd10,
        OP_MUL  = 4'd11,
        OP_DIV  = 4'd12,
        OP_NOP  = 4'd15
    } alu_op_e;

    // Bus sources above the GPR range, relative to NREGS.
    localparam int SRC_HI  = 0;
    localparam int SRC_LO  = 1;
    localparam int SRC_ZHI = 2;
    localparam int SRC_ZLO = 3;
    localparam int SRC_PC  = 4;
    localparam int SRC_MDR = 5;
    localparam int SRC_IN  = 6;
    localparam int SRC_C   = 7;

    // Width of the IR immediate field that is sign-extended onto the bus.
    localparam int C_BITS = 19;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/bus_datapath_p_muldiv.sv
// Radix-2 iterative signed multiply/divide, one bit per cycle for WIDTH cycles.
// Operands are converted to magnitudes at launch; signs are applied to the
// final combinational result so it can be loaded on the last busy edge.
//   clk, rst_n   : clock, asynchronous active-low reset (aborts any operation)
//   start_i      : launch; only honoured while idle
//   is_div_i     : 1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i     : operands A and B (sampled with start_i)
//   state_o      : sequencer state (busy when MD_BUSY)
//   fin_o        : high during the last busy cycle; result_o valid then
//   done_o       : one-cycle pulse in the cycle after fin_o
//   result_o     : {HI, LO}: product, or {remainder, quotient}
module seq_muldiv
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output md_state_e          state_o,
    output logic               fin_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             div_q, qneg_q, rneg_q, bzero_q, done_q;
    logic [WIDTH-1:0] a_q, m_q, hi_q, lo_q;
    logic [WIDTH-1:0] hi_d, lo_d, dsub;
    logic [WIDTH:0]   msum, dshift;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;

    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start_i) state_d = MD_BUSY;
            MD_BUSY: if (cnt_q == LAST) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    assign fin_o   = (state_q == MD_BUSY) && (cnt_q == LAST);
    assign state_o = state_q;
    assign done_o  = done_q;

    // One iteration. Multiply: {hi,lo} holds {partial product, multiplier},
    // m holds the multiplicand. Divide: hi is the partial remainder, lo
    // shifts the dividend out and the quotient in, m holds the divisor.
    always_comb begin
        msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        dshift = {hi_q, lo_q[WIDTH-1]};
        dsub   = dshift[WIDTH-1:0] - m_q;
        if (div_q) begin
            if (dshift >= {1'b0, m_q}) begin
                hi_d = dsub;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = dshift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = msum[WIDTH:1];
            lo_d = {msum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Division by zero bypasses the magnitude path so the dividend comes
    // back unchanged regardless of its sign.
    always_comb begin
        prod = {hi_d, lo_d};
        if (!div_q) begin
            result_o = qneg_q ? -prod : prod;
        end else if (bzero_q) begin
            result_o = {a_q, {WIDTH{1'b1}}};
        end else begin
            result_o = {(rneg_q ? -hi_d : hi_d), (qneg_q ? -lo_d : lo_d)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= fin_o;
            if (state_q == MD_IDLE) begin
                cnt_q <= '0;
                if (start_i) begin
                    div_q   <= is_div_i;
                    a_q     <= a_i;
                    qneg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                    rneg_q  <= a_i[WIDTH-1];
                    bzero_q <= (b_i == '0);
                    hi_q    <= '0;
                    m_q     <= is_div_i ? b_mag : a_mag;
                    lo_q    <= is_div_i ? a_mag : b_mag;
                end
            end else begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bus_datapath_p.sv
// Parametrised single-bus datapath: GPR file, PC/IR/MAR/MDR/Y/HI/LO, Z pair,
// I/O ports, single-cycle ALU and an iterative signed multiply/divide unit.
//   clock, clear          : clock, asynchronous active-low reset
//   bus_src               : encoded bus source (GPRs, then HI..C, else 0)
//   reg_we, reg_idx       : write bus into a GPR
//   pc/ir/mar/y/hi/lo_in  : load bus into that register
//   mdr_in, mem_read      : load MDR from mdata_in (mem_read=1) or the bus
//   z_in, inc_pc, alu_op  : load Z with ALU result or PC+1
//   alu_start/busy/done   : MUL/DIV launch and status
//   in_port_data, out_port_in, out_port : I/O ports
//   bus_out, mar_out, ir_out, pc_out    : observation outputs
module bus_datapath_p
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int RAW   = $clog2(NREGS),
    parameter int SW    = $clog2(NREGS + 8)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [SW-1:0]    bus_src,
    input  logic             reg_we,
    input  logic [RAW-1:0]   reg_idx,
    input  logic             pc_in,
    input  logic             ir_in,
    input  logic             mar_in,
    input  logic             y_in,
    input  logic             hi_in,
    input  logic             lo_in,
    input  logic             mdr_in,
    input  logic             mem_read,
    input  logic [WIDTH-1:0] mdata_in,
    input  logic             z_in,
    input  logic             inc_pc,
    input  logic [3:0]       alu_op,
    input  logic             alu_start,
    output logic             alu_busy,
    output logic             alu_done,
    input  logic [WIDTH-1:0] in_port_data,
    input  logic             out_port_in,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] mar_out,
    output logic [WIDTH-1:0] ir_out,
    output logic [WIDTH-1:0] pc_out
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CB  = (WIDTH < C_BITS) ? WIDTH : C_BITS;

    logic [WIDTH-1:0] gpr_q [NREGS];
    logic [WIDTH-1:0] pc_q, ir_q, mar_q, y_q, hi_q, lo_q, mdr_q;
    logic [WIDTH-1:0] zhi_q, zlo_q, outp_q;
    logic [WIDTH-1:0] bus, c_val, alu_res;
    logic [SW-1:0]    src_off;
    logic [SHW-1:0]   sh;
    logic [2*WIDTH-1:0] rot_r, rot_l, md_result;
    logic             launch, md_fin;
    md_state_e        md_state;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            c_val[i] = (i < CB) ? ir_q[i] : ir_q[CB-1];
        end
    end

    always_comb begin
        bus     = '0;
        src_off = bus_src - SW'(NREGS);
        if (bus_src < SW'(NREGS)) begin
            bus = gpr_q[bus_src[RAW-1:0]];
        end else begin
            case (src_off)
                SW'(SRC_HI):  bus = hi_q;
                SW'(SRC_LO):  bus = lo_q;
                SW'(SRC_ZHI): bus = zhi_q;
                SW'(SRC_ZLO): bus = zlo_q;
                SW'(SRC_PC):  bus = pc_q;
                SW'(SRC_MDR): bus = mdr_q;
                SW'(SRC_IN):  bus = in_port_data;
                SW'(SRC_C):   bus = c_val;
                default:      bus = '0;
            endcase
        end
    end

    // A = Y, B = bus. NEG and NOT are unary on B. Rotates use a doubled
    // copy of A so no shift amount ever reaches WIDTH.
    always_comb begin
        sh      = bus[SHW-1:0];
        rot_r   = {y_q, y_q} >> sh;
        rot_l   = {y_q, y_q} << sh;
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = y_q + bus;
            OP_SUB:  alu_res = y_q - bus;
            OP_AND:  alu_res = y_q & bus;
            OP_OR:   alu_res = y_q | bus;
            OP_SHR:  alu_res = y_q >> sh;
            OP_SHRA: alu_res = $signed(y_q) >>> sh;
            OP_SHL:  alu_res = y_q << sh;
            OP_ROR:  alu_res = rot_r[WIDTH-1:0];
            OP_ROL:  alu_res = rot_l[2*WIDTH-1:WIDTH];
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    assign alu_busy = (md_state == MD_BUSY);
    assign launch   = alu_start && is_iter_op(alu_op) && !alu_busy;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clock),
        .rst_n    (clear),
        .start_i  (launch),
        .is_div_i (alu_op == OP_DIV),
        .a_i      (y_q),
        .b_i      (bus),
        .state_o  (md_state),
        .fin_o    (md_fin),
        .done_o   (alu_done),
        .result_o (md_result)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            mar_q  <= '0;
            y_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            mdr_q  <= '0;
            zhi_q  <= '0;
            zlo_q  <= '0;
            outp_q <= '0;
        end else begin
            if (reg_we)      gpr_q[reg_idx] <= bus;
            if (pc_in)       pc_q   <= bus;
            if (ir_in)       ir_q   <= bus;
            if (mar_in)      mar_q  <= bus;
            if (y_in)        y_q    <= bus;
            if (hi_in)       hi_q   <= bus;
            if (lo_in)       lo_q   <= bus;
            if (out_port_in) outp_q <= bus;
            if (mdr_in)      mdr_q  <= mem_read ? mdata_in : bus;
            // The iterative unit owns Z while busy; a launch beats z_in.
            if (md_fin) begin
                {zhi_q, zlo_q} <= md_result;
            end else if (z_in && !alu_busy && !launch) begin
                zlo_q <= inc_pc ? pc_q + WIDTH'(1) : alu_res;
                zhi_q <= '0;
            end
        end
    end

    assign out_port = outp_q;
    assign bus_out  = bus;
    assign mar_out  = mar_q;
    assign ir_out   = ir_q;
    assign pc_out   = pc_q;

endmodule

// File: doc/bus_datapath_p.md
Name: bus_datapath_p

Overview:
- Parametrised successor to the phase-1 single-bus datapath.
- Width and register count are generics; bus source selection is an encoded index, not one-hot strobes.
- Adds an iterative multiply/divide unit with a start/busy/done handshake, loading 2×WIDTH results into ZHI/ZLO.
- Sits under the control unit; memory and I/O ports connect to the top level.

Parameters:
- WIDTH, 32, datapath/bus width in bits (≥8).
- NREGS, 16, general-purpose register count (power of 2, ≥4).
- RAW, $clog2(NREGS), register index width.
- SW, $clog2(NREGS+8), bus source select width.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- bus_src  in  SW  bus source index
- reg_we  in  1  write bus into GPR reg_idx
- reg_idx  in  RAW  GPR write index
- pc_in, ir_in, mar_in, y_in, hi_in, lo_in  in  1 each  load bus into that register
- mdr_in  in  1  load MDR
- mem_read  in  1  MDR source: 1 = mdata_in, 0 = bus
- mdata_in  in  WIDTH  memory read data
- z_in  in  1  load Z from single-cycle ALU result
- inc_pc  in  1  with z_in: ZLO ← PC+1
- alu_op  in  4  operation code (pkg)
- alu_start  in  1  launch MUL/DIV
- alu_busy  out  1  iterative op in progress
- alu_done  out  1  one-cycle completion pulse
- in_port_data  in  WIDTH  input port value
- out_port_in  in  1  load bus into output port register
- out_port  out  WIDTH  output port register
- bus_out  out  WIDTH  current bus value
- mar_out, ir_out, pc_out  out  WIDTH  register contents

Behaviour:
- Reset (clear=0, async): all registers, including GPRs, Y, Z, HI, LO, MDR, out_port and muldiv state, go to 0. alu_busy=0, alu_done=0. Reset during busy aborts the operation; Z is not written.
- Bus source index:
  - 0..NREGS-1: GPRs
  - NREGS+0: HI, +1: LO, +2: ZHI, +3: ZLO, +4: PC, +5: MDR, +6: in_port_data, +7: C, where C = sign-extended IR[18:0]
  - Any index ≥ NREGS+8: bus = 0.
- Bus is combinational. A load in a cycle samples the pre-edge bus value, so reading and writing the same register in one cycle returns the old value.
- Single-cycle ops (ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT):
  - A = Y, B = bus.
  - Shift/rotate amount = B[$clog2(WIDTH)-1:0].
  - On z_in: ZLO ← result, ZHI ← 0. Arithmetic wraps modulo 2^WIDTH.
- inc_pc with z_in: ZLO ← PC+1, ZHI ← 0. inc_pc overrides alu_op.
- MUL/DIV handshake:
  - alu_start=1 with alu_op MUL or DIV and alu_busy=0 latches A=Y and B=bus.
  - alu_busy=1 from the next cycle for exactly WIDTH cycles.
  - On the last busy cycle's edge, {ZHI,ZLO} is loaded, busy drops and alu_done pulses high for 1 cycle.
  - Total latency from start edge to result visible = WIDTH+1 edges.
- MUL: signed A×B, full 2·WIDTH product, {ZHI,ZLO} = product.
- DIV: signed. ZLO = quotient truncated toward zero; ZHI = remainder with the sign of the dividend.
  - B=0: ZLO = all ones, ZHI = A, same latency.
  - Most-negative ÷ −1: ZLO = most-negative, ZHI = 0.
- While alu_busy: alu_start and z_in are ignored (no Z write, no relaunch); all other loads proceed normally.
- alu_start with a non-iterative op is ignored.
- alu_start and z_in in the same idle cycle with MUL/DIV: the start wins, and the z_in write is suppressed.

Decomposition:
- Package bus_datapath_pkg holds:
  - alu_op enum: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHRA=5, SHL=6, ROR=7, ROL=8, NEG=9, NOT=10, MUL=11, DIV=12; others = NOP (result 0).
  - Bus source offset constants (SRC_HI … SRC_C relative to NREGS).
- One sub-module, seq_muldiv: radix-2 iterative signed mul/div. It owns the WIDTH-cycle counter and the busy/done generation.

Test Plan:
1. Y←5 via R1, bus=R2=7, alu_op ADD, z_in → ZLO=12, ZHI=0. Then SUB with Y=5, B=7 → ZLO=0xFFFFFFFE.
2. Y=−3 (0xFFFFFFFD), B=0x10000, MUL start → busy for exactly 32 cycles, done pulse once, {ZHI,ZLO}=0xFFFFFFFF_FFFD0000.
3. Y=−7, B=2, DIV → ZLO=0xFFFFFFFD (−3), ZHI=0xFFFFFFFF (−1). Y=7, B=0 → ZLO=0xFFFFFFFF, ZHI=7.
4. MUL started, clear pulsed low at busy cycle 10 → busy=0, done never pulses, Z=0, all GPRs=0.
5. During busy: z_in with ADD and a second alu_start → Z unchanged until done, no second done pulse. reg_we to R3 still takes effect.
6. bus_src=NREGS+7 with IR[18:0]=0x40000 → bus=0xFFFC0000. bus_src=NREGS+9 → bus=0. reg_we R4 while bus_src=R4 → bus shows old value that cycle.
